mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_port.sv | 45 ++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned RD_LAT_DEF     = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;

  localparam logic ID_C = 1'b0;
  localparam logic ID_D = 1'b1;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 3;

  // One slot of the load-return pipeline: which requester owns the load in flight.
  typedef struct packed {
    logic valid;
    logic id;
  } owner_t;

endpackage

// File: rtl/arb_port.sv
// Two-way fixed priority (C over D) for one memory port, with a starvation escape for D.
module arb_port
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic d_req,
  // D is held off this cycle by an address collision; it neither competes nor ages.
  input  logic d_defer,
  output logic c_gnt,
  output logic d_gnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_elig;
  logic             starve;

  assign d_elig = d_req & ~d_defer;
  assign starve = d_elig & (cnt_q == CNT_W'(STARVE_MAX));
  assign c_gnt  = c_req & ~starve;
  assign d_gnt  = d_elig & (~c_req | starve);

  // Count consecutive denied D cycles; clear on grant or on D withdrawing.
  always_comb begin
    cnt_d = cnt_q;
    if (!d_req || d_gnt) begin
      cnt_d = '0;
    end else if (!d_defer && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter onto a memory with independent read and write ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  logic c_ld, c_st, d_ld, d_st, same_addr;
  logic c_ld_blk, d_ld_blk;
  logic rd_c_gnt, rd_d_gnt, wr_c_gnt, wr_d_gnt;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  owner_t [RD_LAT-1:0] pipe_q, pipe_d;
  owner_t head;

  // we selects: a requester issues either a load or a store, never both.
  assign c_ld      = c_req & ~c_we;
  assign c_st      = c_req & c_we;
  assign d_ld      = d_req & ~d_we;
  assign d_st      = d_req & d_we;
  assign same_addr = (c_addr == d_addr);

  // Write-before-read: a load colliding with the other side's store waits a cycle.
  assign c_ld_blk = c_ld & d_st & same_addr;
  assign d_ld_blk = d_ld & c_st & same_addr;

  arb_port #(.STARVE_MAX(STARVE_MAX)) u_rd_port (
    .clk    (clk),
    .rst_n  (rst_n),
    .c_req  (c_ld & ~c_ld_blk),
    .d_req  (d_ld),
    .d_defer(d_ld_blk),
    .c_gnt  (rd_c_gnt),
    .d_gnt  (rd_d_gnt)
  );

  arb_port #(.STARVE_MAX(STARVE_MAX)) u_wr_port (
    .clk    (clk),
    .rst_n  (rst_n),
    .c_req  (c_st),
    .d_req  (d_st),
    .d_defer(1'b0),
    .c_gnt  (wr_c_gnt),
    .d_gnt  (wr_d_gnt)
  );

  // Grants and memory port drive; reset masks everything combinationally.
  always_comb begin
    raddr_d = raddr_q;
    if (rd_c_gnt) begin
      raddr_d = c_addr;
    end else if (rd_d_gnt) begin
      raddr_d = d_addr;
    end
    c_gnt     = rst_n & (rd_c_gnt | wr_c_gnt);
    d_gnt     = rst_n & (rd_d_gnt | wr_d_gnt);
    mem_raddr = rst_n ? raddr_d : '0;
    mem_wen   = rst_n & (wr_c_gnt | wr_d_gnt);
    mem_waddr = wr_d_gnt ? d_addr : c_addr;
    mem_wdata = wr_d_gnt ? d_wdata : c_wdata;
  end

  // Owner pipeline: slot 0 takes this cycle's load grant, the last slot is due now.
  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = rd_c_gnt | rd_d_gnt;
    pipe_d[0].id    = rd_d_gnt ? ID_D : ID_C;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Read address hold and owner pipeline registers; reset drops loads in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
      pipe_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      pipe_q  <= pipe_d;
    end
  end

  // Load return: at most one owner per cycle since the pipeline holds one entry per slot.
  always_comb begin
    head     = pipe_q[RD_LAT-1];
    c_rvalid = head.valid & (head.id == ID_C);
    d_rvalid = head.valid & (head.id == ID_D);
    rdata    = head.valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: RD_LAT=2 arbiter plus an RD_LAT=1 copy sharing the same stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [14:0] c_addr, d_addr;
  logic [15:0] c_wdata, d_wdata;

  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, mem_wen;
  logic [15:0] rdata, mem_rdata, mem_wdata;
  logic [14:0] mem_raddr, mem_waddr;

  logic        c_gnt2, d_gnt2, c_rvalid2, d_rvalid2, mem_wen2;
  logic [15:0] rdata2, mem_rdata2, mem_wdata2;
  logic [14:0] mem_raddr2, mem_waddr2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .rdata(rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  mem_arbiter #(.RD_LAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .c_gnt(c_gnt2), .d_gnt(d_gnt2), .c_rvalid(c_rvalid2), .d_rvalid(d_rvalid2),
    .rdata(rdata2), .mem_raddr(mem_raddr2), .mem_rdata(mem_rdata2),
    .mem_wen(mem_wen2), .mem_waddr(mem_waddr2), .mem_wdata(mem_wdata2)
  );

  // Memory model: mem[a] starts as 0x1000+a; reads are pipelined per instance latency.
  logic [15:0] mem [32768];
  logic [15:0] rd1_s0, rd1_s1, rd2_s0;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i);
  end

  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    rd1_s0 <= mem[mem_raddr];
    rd1_s1 <= rd1_s0;
    rd2_s0 <= mem[mem_raddr2];
  end

  assign mem_rdata  = rd1_s1;
  assign mem_rdata2 = rd2_s0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset: a pending C load must not leak through.
    @(negedge clk);
    c_req = 1'b1; c_addr = 15'h0010;
    #1;
    chk("rst_c_gnt", 16'(c_gnt), 16'd0);
    chk("rst_d_gnt", 16'(d_gnt), 16'd0);
    chk("rst_c_rvalid", 16'(c_rvalid), 16'd0);
    chk("rst_d_rvalid", 16'(d_rvalid), 16'd0);
    chk("rst_mem_wen", 16'(mem_wen), 16'd0);
    chk("rst_mem_raddr", 16'(mem_raddr), 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // C load 0x0010 alone.
    @(negedge clk);
    c_req = 1'b1; c_addr = 15'h0010;
    #1;
    chk("t1_c_gnt", 16'(c_gnt), 16'd1);
    chk("t1_d_gnt", 16'(d_gnt), 16'd0);
    chk("t1_mem_raddr", 16'(mem_raddr), 16'h0010);
    chk("t1_mem_wen", 16'(mem_wen), 16'd0);
    @(negedge clk);
    idle();
    #1;
    chk("t1_rv_early", 16'(c_rvalid), 16'd0);
    chk("t1_raddr_hold", 16'(mem_raddr), 16'h0010);
    @(negedge clk);
    #1;
    chk("t1_c_rvalid", 16'(c_rvalid), 16'd1);
    chk("t1_d_rvalid", 16'(d_rvalid), 16'd0);
    chk("t1_rdata", rdata, 16'h1010);

    // C store 0x0020 with D load 0x0030: both ports granted.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 15'h0020; c_wdata = 16'hCAFE;
    d_req = 1'b1; d_we = 1'b0; d_addr = 15'h0030;
    #1;
    chk("t2_c_gnt", 16'(c_gnt), 16'd1);
    chk("t2_d_gnt", 16'(d_gnt), 16'd1);
    chk("t2_mem_wen", 16'(mem_wen), 16'd1);
    chk("t2_mem_waddr", 16'(mem_waddr), 16'h0020);
    chk("t2_mem_wdata", mem_wdata, 16'hCAFE);
    chk("t2_mem_raddr", 16'(mem_raddr), 16'h0030);
    chk("t2_mem_wen2", 16'(mem_wen2), 16'd1);
    chk("t2_mem_waddr2", 16'(mem_waddr2), 16'h0020);
    chk("t2_mem_wdata2", mem_wdata2, 16'hCAFE);
    @(negedge clk);
    idle();
    #1;
    chk("t2_wen_off", 16'(mem_wen), 16'd0);
    @(negedge clk);
    #1;
    chk("t2_d_rvalid", 16'(d_rvalid), 16'd1);
    chk("t2_c_rvalid", 16'(c_rvalid), 16'd0);
    chk("t2_rdata", rdata, 16'h1030);

    // C and D load continuously: D wins on the 5th cycle, C again on the 6th.
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 15'h0100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 15'h0200;
      #1;
      chk($sformatf("t3_c_gnt_%0d", i), 16'(c_gnt), 16'(i != 5));
      chk($sformatf("t3_d_gnt_%0d", i), 16'(d_gnt), 16'(i == 5));
      chk($sformatf("t3_c_rv_%0d", i), 16'(c_rvalid), 16'((i >= 3) && (i != 7)));
      chk($sformatf("t3_d_rv_%0d", i), 16'(d_rvalid), 16'(i == 7));
    end
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);

    // C store 0x0040=0xBEEF collides with D load 0x0040: store first, load next cycle.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 15'h0040; c_wdata = 16'hBEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 15'h0040;
    #1;
    chk("t4_c_gnt", 16'(c_gnt), 16'd1);
    chk("t4_d_gnt", 16'(d_gnt), 16'd0);
    chk("t4_mem_wen", 16'(mem_wen), 16'd1);
    chk("t4_mem_waddr", 16'(mem_waddr), 16'h0040);
    @(negedge clk);
    c_req = 1'b0; c_we = 1'b0;
    #1;
    chk("t4_d_gnt_retry", 16'(d_gnt), 16'd1);
    chk("t4_mem_raddr", 16'(mem_raddr), 16'h0040);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    chk("t4_d_rvalid", 16'(d_rvalid), 16'd1);
    chk("t4_rdata", rdata, 16'hBEEF);

    // C, D, C loads back to back, then reset one cycle after the third grant.
    @(negedge clk);
    c_req = 1'b1; c_addr = 15'h0050;
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b1; d_addr = 15'h0060;
    @(negedge clk);
    d_req = 1'b0; c_req = 1'b1; c_addr = 15'h0070;
    #1;
    chk("t5_c_gnt3", 16'(c_gnt), 16'd1);
    chk("t5_c_rvalid1", 16'(c_rvalid), 16'd1);
    chk("t5_rdata1", rdata, 16'h1050);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_c_gnt", 16'(c_gnt), 16'd0);
    chk("t5_rst_d_gnt", 16'(d_gnt), 16'd0);
    chk("t5_rst_c_rv", 16'(c_rvalid), 16'd0);
    chk("t5_rst_d_rv", 16'(d_rvalid), 16'd0);
    chk("t5_rst_wen", 16'(mem_wen), 16'd0);
    chk("t5_rst_raddr", 16'(mem_raddr), 16'h0000);
    chk("t5_rst_rdata", rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_post_c_rv_%0d", i), 16'(c_rvalid), 16'd0);
      chk($sformatf("t5_post_d_rv_%0d", i), 16'(d_rvalid), 16'd0);
      @(negedge clk);
    end

    // RD_LAT=1 copy: alternating C/D loads return alternately, one per cycle.
    for (int i = 0; i <= 4; i++) begin
      idle();
      if (i < 4) begin
        if (i % 2 == 0) begin
          c_req = 1'b1; c_addr = 15'h0080 + 15'(i);
        end else begin
          d_req = 1'b1; d_addr = 15'h0080 + 15'(i);
        end
      end
      #1;
      if (i < 4) begin
        chk($sformatf("t6_c_gnt2_%0d", i), 16'(c_gnt2), 16'(i % 2 == 0));
        chk($sformatf("t6_d_gnt2_%0d", i), 16'(d_gnt2), 16'(i % 2 == 1));
      end
      if (i >= 1) begin
        chk($sformatf("t6_c_rv2_%0d", i), 16'(c_rvalid2), 16'((i - 1) % 2 == 0));
        chk($sformatf("t6_d_rv2_%0d", i), 16'(d_rvalid2), 16'((i - 1) % 2 == 1));
        chk($sformatf("t6_rdata2_%0d", i), rdata2, 16'h1080 + 16'(i - 1));
      end else begin
        chk("t6_rv2_none", 16'(c_rvalid2 | d_rvalid2), 16'd0);
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
